// File: rtl/maverickOne_pkg.sv
// Shared constants for the maverickOne integer pipeline, including register-file sizing.
package maverickOne_pkg;

  localparam int NUM_REGS    = 64;
  localparam int XLEN        = 64;
  localparam int REGFILE_NRP = 3;
  localparam int REGFILE_NWP = 2;
  localparam int REGFILE_LCW = 2;

  // Width needed to count 0..n simultaneous write-port hits on one register.
  function automatic int hit_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_counter.sv
// Per-register outstanding-lock counter: +1 on accepted lock, -dec on write-unlocks,
// clamped at zero with an underflow pulse when more unlocks arrive than locks exist.
module lock_counter #(
  parameter int LCW = 2,
  parameter int DCW = 2
) (
  input  logic           clk_i,
  input  logic           arst_i,
  input  logic           inc_i,
  input  logic [DCW-1:0] dec_i,
  output logic [LCW-1:0] count_o,
  output logic           sat_o,
  output logic           underflow_o
);

  localparam int SW = ((LCW > DCW) ? LCW : DCW) + 1;

  logic [LCW-1:0] count_q, count_d;
  logic [SW-1:0]  avail;
  logic [SW-1:0]  dec_ext;

  // avail can reach 2^LCW only when a saturated lock is paired with an unlock,
  // so the extra bit keeps the intermediate sum exact.
  always_comb begin
    avail       = SW'(count_q) + SW'(inc_i);
    dec_ext     = SW'(dec_i);
    underflow_o = dec_ext > avail;
    count_d     = underflow_o ? '0 : LCW'(avail - dec_ext);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign sat_o   = &count_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and per-register lock counters
// tracking outstanding producer writes between issue and writeback.
module regfile_mp
  import maverickOne_pkg::*;
#(
  parameter  int NR  = NUM_REGS,
  parameter  int DW  = XLEN,
  parameter  int NRP = REGFILE_NRP,
  parameter  int NWP = REGFILE_NWP,
  parameter  int LCW = REGFILE_LCW,
  localparam int AW  = $clog2(NR)
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [NWP-1:0]           wr_en_i,
  input  logic [NWP-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWP-1:0][DW-1:0]   wr_data_i,
  input  logic                     lock_en_i,
  input  logic [AW-1:0]            lock_addr_i,
  output logic                     lock_ready_o,
  input  logic [NRP-1:0][AW-1:0]   rd_addr_i,
  output logic [NRP-1:0][DW-1:0]   rd_data_o,
  output logic [NR-1:0]            locks_o,
  output logic                     underflow_o
);

  localparam int HW = hit_width(NWP);

  logic [DW-1:0]  regs_q [NR];
  logic [HW-1:0]  hits   [NR];
  logic [DW-1:0]  wr_sel [NR];
  logic [LCW-1:0] cnt    [NR];
  logic [NR-1:0]  wr_hit, sat, uf_pulse, lock_acc, locked;
  logic           underflow_q, underflow_d;

  for (genvar gi = 0; gi < NR; gi++) begin : g_addr
    // Ascending port scan so the highest-index matching port overrides data.
    always_comb begin
      hits[gi]   = '0;
      wr_hit[gi] = 1'b0;
      wr_sel[gi] = '0;
      for (int p = 0; p < NWP; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p] == AW'(gi))) begin
          hits[gi]   = hits[gi] + HW'(1);
          wr_hit[gi] = 1'b1;
          wr_sel[gi] = wr_data_i[p];
        end
      end
    end

    if (gi != 0) begin : g_cnt
      assign lock_acc[gi] = lock_en_i && lock_ready_o && (lock_addr_i == AW'(gi));

      lock_counter #(.LCW(LCW), .DCW(HW)) u_lock_counter (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .inc_i       (lock_acc[gi]),
        .dec_i       (hits[gi]),
        .count_o     (cnt[gi]),
        .sat_o       (sat[gi]),
        .underflow_o (uf_pulse[gi])
      );

      assign locked[gi] = 32'(cnt[gi]) > 32'(hits[gi]);
    end else begin : g_zero
      assign lock_acc[gi] = 1'b0;
      assign cnt[gi]      = '0;
      assign sat[gi]      = 1'b0;
      assign uf_pulse[gi] = 1'b0;
      assign locked[gi]   = 1'b0;
    end
  end

  // A saturated register can still take a lock when an unlock lands in the same cycle.
  assign lock_ready_o = (lock_addr_i == '0) || !sat[lock_addr_i] || (hits[lock_addr_i] != '0);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int a = 0; a < NR; a++) regs_q[a] <= '0;
    end else begin
      for (int a = 1; a < NR; a++) begin
        if (wr_hit[a]) regs_q[a] <= wr_sel[a];
      end
    end
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    always_comb begin
      rd_data_o[gi] = '0;
      if (rd_addr_i[gi] != '0) begin
        rd_data_o[gi] = wr_hit[rd_addr_i[gi]] ? wr_sel[rd_addr_i[gi]] : regs_q[rd_addr_i[gi]];
      end
    end
  end

  assign underflow_d = underflow_q || (|uf_pulse);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) underflow_q <= 1'b0;
    else        underflow_q <= underflow_d;
  end

  assign underflow_o = underflow_q;
  assign locks_o     = arst_i ? '1 : locked;

endmodule
